// File: rtl/audio_pll_lock_sequencer.sv
// rtl/audio_pll_lock_sequencer.sv - audio PLL reset pulse, lock qualification, retry/fault and ordered reset release
module audio_pll_lock_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 50,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned RELEASE_GAP_CYCLES  = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_0,
  output logic       sys_rst_1,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  localparam int unsigned MAX_AB  = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CD  = (LOCK_TIMEOUT_CYCLES > RELEASE_GAP_CYCLES) ? LOCK_TIMEOUT_CYCLES : RELEASE_GAP_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(RELEASE_GAP_CYCLES - 1);
  localparam logic [3:0]    MAX_R    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic          sync1_q, sync2_q;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_rst_0_q, sys_rst_0_d;
  logic          sys_rst_1_q, sys_rst_1_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic          fail;
  logic          locked_s;

  assign locked_s = sync2_q;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = cnt_q + CW'(1);
    fail    = 1'b0;

    if (restart) begin
      state_d = S_RESET_PLL;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RESET_PLL: if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        // Lock is tested before the timeout so a lock on the final cycle still wins.
        S_WAIT_LOCK: begin
          if (locked_s)                state_d = S_STABLE;
          else if (cnt_q == TMO_LAST)  fail    = 1'b1;
        end
        S_STABLE: begin
          if (!locked_s)               fail    = 1'b1;
          else if (cnt_q == STB_LAST)  state_d = S_RELEASE;
        end
        S_RELEASE: begin
          if (!locked_s) begin
            state_d = S_RESET_PLL;
            retry_d = '0;
          end else if (cnt_q == GAP_LAST) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_d = S_RESET_PLL;
            retry_d = '0;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_RESET_PLL;
      endcase

      if (fail) begin
        if (retry_q == MAX_R) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_RESET_PLL;
          if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
        end
      end
    end

    // Restart into RESET_PLL from RESET_PLL is still a fresh pulse.
    if (state_d != state_q || restart) cnt_d = '0;

    pll_rst_d   = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
    sys_rst_0_d = !((state_d == S_RELEASE) || (state_d == S_RUN));
    sys_rst_1_d = (state_d != S_RUN);
    ready_d     = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_0_q <= 1'b1;
      sys_rst_1_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      sync1_q     <= pll_locked;
      sync2_q     <= sync1_q;
      pll_rst_q   <= pll_rst_d;
      sys_rst_0_q <= sys_rst_0_d;
      sys_rst_1_q <= sys_rst_1_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst_0   = sys_rst_0_q;
  assign sys_rst_1   = sys_rst_1_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule

// File: tb/tb_audio_pll_lock_sequencer.sv
// tb/tb_audio_pll_lock_sequencer.sv - directed and random bench for audio_pll_lock_sequencer against a cycle-age reference model
module tb_audio_pll_lock_sequencer;

  localparam int P_RST  = 4;
  localparam int P_STB  = 8;
  localparam int P_TMO  = 32;
  localparam int P_MAXR = 2;
  localparam int P_GAP  = 3;
  localparam int LIMIT  = 200;

  localparam int M_RST  = 0;
  localparam int M_WAIT = 1;
  localparam int M_QUAL = 2;
  localparam int M_REL  = 3;
  localparam int M_RUN  = 4;
  localparam int M_FLT  = 5;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, sys_rst_0, sys_rst_1, ready, fault;
  logic [3:0] retry_count;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  audio_pll_lock_sequencer #(
    .RST_PULSE_CYCLES   (P_RST),
    .LOCK_STABLE_CYCLES (P_STB),
    .LOCK_TIMEOUT_CYCLES(P_TMO),
    .MAX_RETRIES        (P_MAXR),
    .RELEASE_GAP_CYCLES (P_GAP)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .sys_rst_0  (sys_rst_0),
    .sys_rst_1  (sys_rst_1),
    .ready      (ready),
    .fault      (fault),
    .retry_count(retry_count),
    .state      (state)
  );

  always #10 refclk = ~refclk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode plus cycles spent in it, lock seen two edges late.
  int m_mode = 0;
  int m_age = 0;
  int m_retries = 0;
  bit m_s1 = 1'b0;
  bit m_s2 = 1'b0;
  bit m_valid = 1'b0;

  task automatic go(input int m);
    m_mode = m;
    m_age  = 0;
  endtask

  always @(posedge refclk) begin
    bit ls;
    bit failed;
    ls = m_s2;
    failed = 1'b0;
    if (rst) begin
      m_valid = 1'b1;
      go(M_RST);
      m_retries = 0;
      m_s1 = 1'b0;
      m_s2 = 1'b0;
    end else begin
      m_s2 = m_s1;
      m_s1 = pll_locked;
      if (restart) begin
        go(M_RST);
        m_retries = 0;
      end else begin
        m_age++;
        case (m_mode)
          M_RST:  if (m_age == P_RST) go(M_WAIT);
          M_WAIT: if (ls) go(M_QUAL); else if (m_age == P_TMO) failed = 1'b1;
          M_QUAL: if (!ls) failed = 1'b1; else if (m_age == P_STB) go(M_REL);
          M_REL:  if (!ls) begin go(M_RST); m_retries = 0; end else if (m_age == P_GAP) go(M_RUN);
          M_RUN:  if (!ls) begin go(M_RST); m_retries = 0; end
          default: ;
        endcase
        if (failed) begin
          if (m_retries == P_MAXR) go(M_FLT);
          else begin
            m_retries++;
            go(M_RST);
          end
        end
      end
    end
  end

  always @(negedge refclk) begin
    if (m_valid) begin
      chk("m_state", int'(state), m_mode);
      chk("m_pll_rst", int'(pll_rst), int'(m_mode == M_RST || m_mode == M_FLT));
      chk("m_sys_rst_0", int'(sys_rst_0), int'(!(m_mode == M_REL || m_mode == M_RUN)));
      chk("m_sys_rst_1", int'(sys_rst_1), int'(m_mode != M_RUN));
      chk("m_ready", int'(ready), int'(m_mode == M_RUN));
      chk("m_fault", int'(fault), int'(m_mode == M_FLT));
      chk("m_retry", int'(retry_count), m_retries);
      chk("m_order", int'(!sys_rst_1 && sys_rst_0), 0);
    end
  end

  function automatic int sig(input int sel);
    case (sel)
      0: return int'(pll_rst);
      1: return int'(sys_rst_0);
      2: return int'(ready);
      3: return int'(state);
      4: return int'(fault);
      default: return int'(sys_rst_1);
    endcase
  endfunction

  task automatic wait_cnt(input string tag, input int sel, input int val, output int n);
    n = 0;
    while (sig(sel) != val && n < LIMIT) begin
      @(negedge refclk);
      n++;
    end
    chk({tag, "_bound"}, int'(n < LIMIT), 1);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge refclk);
    restart = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end by itself");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge refclk);
    chk("rst_pll_rst", int'(pll_rst), 1);
    chk("rst_sys_rst_0", int'(sys_rst_0), 1);
    chk("rst_sys_rst_1", int'(sys_rst_1), 1);
    chk("rst_ready", int'(ready), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_retry", int'(retry_count), 0);
    chk("rst_state", int'(state), 0);

    // Nominal bring-up
    rst = 1'b0;
    wait_cnt("nom_pulse", 0, 0, n);
    chk("nom_pll_rst_width", n, P_RST);
    repeat (10) @(negedge refclk);
    pll_locked = 1'b1;
    wait_cnt("nom_stable", 3, 2, n);
    wait_cnt("nom_qual", 1, 0, n);
    chk("nom_qual_time", n, P_STB);
    wait_cnt("nom_gap", 2, 1, n);
    chk("nom_gap_time", n, P_GAP);
    chk("nom_sys_rst_1", int'(sys_rst_1), 0);
    chk("nom_retry", int'(retry_count), 0);

    // Lock loss in RUN
    pll_locked = 1'b0;
    wait_cnt("loss", 2, 0, n);
    chk("loss_latency_le3", int'(n <= 3), 1);
    chk("loss_sys_rst_0", int'(sys_rst_0), 1);
    chk("loss_sys_rst_1", int'(sys_rst_1), 1);
    chk("loss_retry", int'(retry_count), 0);
    pll_locked = 1'b1;
    wait_cnt("relock", 2, 1, n);
    chk("relock_ready", int'(ready), 1);
    chk("relock_retry", int'(retry_count), 0);

    // Glitch during qualification
    pulse_restart();
    chk("rs_run_state", int'(state), 0);
    wait_cnt("gl_stable", 3, 2, n);
    repeat (2) @(negedge refclk);
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    pll_locked = 1'b1;
    wait_cnt("gl_fail", 0, 1, n);
    chk("gl_retry", int'(retry_count), 1);
    chk("gl_sys_rst_0", int'(sys_rst_0), 1);
    wait_cnt("gl_pulse", 0, 0, n);
    chk("gl_pulse_width", n, P_RST);
    wait_cnt("gl_ready", 2, 1, n);
    chk("gl_retry_kept", int'(retry_count), 1);

    // Never locks
    pll_locked = 1'b0;
    pulse_restart();
    chk("nl_pll_rst_start", int'(pll_rst), 1);
    for (int i = 0; i < 3; i++) begin
      wait_cnt("nl_pulse", 0, 0, n);
      chk("nl_pulse_width", n, P_RST);
      wait_cnt("nl_wait", 0, 1, n);
      chk("nl_wait_len", n, P_TMO);
    end
    chk("nl_fault", int'(fault), 1);
    chk("nl_retry", int'(retry_count), P_MAXR);
    chk("nl_state", int'(state), 5);
    repeat (10) @(negedge refclk);
    chk("nl_pll_rst_stuck", int'(pll_rst), 1);
    chk("nl_fault_stuck", int'(fault), 1);

    // Restart in FAULT
    pulse_restart();
    chk("rf_fault", int'(fault), 0);
    chk("rf_retry", int'(retry_count), 0);
    chk("rf_pll_rst", int'(pll_rst), 1);
    chk("rf_state", int'(state), 0);

    // Restart in RELEASE
    pll_locked = 1'b1;
    wait_cnt("rl_release", 3, 3, n);
    chk("rl_sys_rst_0_low", int'(sys_rst_0), 0);
    pulse_restart();
    chk("rl_sys_rst_0", int'(sys_rst_0), 1);
    chk("rl_state", int'(state), 0);

    // Reset mid-WAIT_LOCK
    pll_locked = 1'b0;
    wait_cnt("rw_wait", 3, 1, n);
    repeat (5) @(negedge refclk);
    rst = 1'b1;
    @(negedge refclk);
    rst = 1'b0;
    chk("rw_pll_rst", int'(pll_rst), 1);
    chk("rw_sys_rst_0", int'(sys_rst_0), 1);
    chk("rw_sys_rst_1", int'(sys_rst_1), 1);
    chk("rw_ready", int'(ready), 0);
    chk("rw_fault", int'(fault), 0);
    chk("rw_state", int'(state), 0);

    // Random lock runs with occasional restart and reset
    for (int c = 0; c < 4000; ) begin
      int len;
      pll_locked = ~pll_locked;
      len = pll_locked ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 160));
      for (int k = 0; k < len; k++) begin
        restart = ($urandom_range(0, 299) == 0);
        rst     = ($urandom_range(0, 499) == 0);
        @(negedge refclk);
        c++;
      end
    end
    restart = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge refclk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
